io_responder: RTL

- Peripheral-side counterpart of the control unit's I/O sequence. It answers the CPU's IN/OUT strobe (ioe) and the INT pulse (intreq).
- Buffers data to and from an external device through two small FIFOs with valid/ready handshakes.
- Holds a general-purpose output register and a status word.
- Raises an interrupt line toward the external device, held until it is acknowledged.

---
 rtl/io_responder_if.sv | 37 +++
 rtl/io_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/io_responder_if.sv
// Bus bundle between the control unit / external device and io_responder.
// master = environment (CPU strobes, external producer/consumer), slave = responder.
interface io_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              ioe;
  logic              io_wr;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_rdata;
  logic              intreq;
  logic              irq_out;
  logic [ADDR_W-1:0] irq_vec;
  logic              irq_ack;
  logic [DATA_W-1:0] ext_in_data;
  logic              ext_in_valid;
  logic              ext_in_ready;
  logic [DATA_W-1:0] ext_out_data;
  logic              ext_out_valid;
  logic              ext_out_ready;
  logic [DATA_W-1:0] gpo;

  modport master (
    output ioe, io_wr, io_addr, io_wdata, intreq, irq_ack,
           ext_in_data, ext_in_valid, ext_out_ready,
    input  io_rdata, irq_out, irq_vec, ext_in_ready,
           ext_out_data, ext_out_valid, gpo
  );

  modport slave (
    input  ioe, io_wr, io_addr, io_wdata, intreq, irq_ack,
           ext_in_data, ext_in_valid, ext_out_ready,
    output io_rdata, irq_out, irq_vec, ext_in_ready,
           ext_out_data, ext_out_valid, gpo
  );
endinterface

// File: rtl/io_responder.sv
// io_responder: peripheral side of the CPU IN/OUT/INT sequence.
// RX/TX FIFOs toward an external device, GPO register, status word with
// read-to-clear sticky bits, and a held interrupt line with latched vector.

// Small synchronous FIFO. Push is refused when full and pop ignored when
// empty, both judged on the state before the edge, so a simultaneous pop
// never makes room for a push into a full FIFO.
module io_responder_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              i_init,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_empty,
  output logic              o_full
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [PW-1:0]                r_wp;
  logic [PW-1:0]                r_rp;
  logic [PW:0]                  r_cnt;
  logic                         w_push;
  logic                         w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  // Head reads as zero when empty so the consumer never sees stale data.
  assign o_head  = o_empty ? '0 : r_mem[r_rp];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (i_init) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module io_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           init,
  io_responder_if.slave bus
);
  localparam logic [1:0]        A_DATA   = 2'd0;
  localparam logic [1:0]        A_STATUS = 2'd1;
  localparam logic [1:0]        A_GPO    = 2'd2;
  localparam logic [1:0]        A_ID     = 2'd3;
  localparam logic [DATA_W-1:0] L_ID     = DATA_W'(16'h1D01);

  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_gpo;
  logic              r_irq_out;
  logic [ADDR_W-1:0] r_irq_vec;
  // {irq_overrun, tx_overflow, rx_underflow}
  logic [2:0]        r_sticky;

  logic              w_in;
  logic              w_out;
  logic              w_addr_ok;
  logic [1:0]        w_sel;
  logic              w_rx_rd;
  logic              w_tx_wr;
  logic              w_stat_rd;
  logic              w_gpo_wr;
  logic [DATA_W-1:0] w_rx_head;
  logic              w_rx_empty;
  logic              w_rx_full;
  logic [DATA_W-1:0] w_tx_head;
  logic              w_tx_empty;
  logic              w_tx_full;
  logic [2:0]        w_set;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd_val;

  // Strobe decode; only addresses 0..3 select anything.
  assign w_in      = bus.ioe && !bus.io_wr;
  assign w_out     = bus.ioe && bus.io_wr;
  assign w_addr_ok = ((bus.io_addr >> 2) == '0);
  assign w_sel     = bus.io_addr[1:0];
  assign w_rx_rd   = w_in  && w_addr_ok && (w_sel == A_DATA);
  assign w_stat_rd = w_in  && w_addr_ok && (w_sel == A_STATUS);
  assign w_tx_wr   = w_out && w_addr_ok && (w_sel == A_DATA);
  assign w_gpo_wr  = w_out && w_addr_ok && (w_sel == A_GPO);

  io_responder_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk     (clk),
    .i_init  (init),
    .i_push  (bus.ext_in_valid),
    .i_wdata (bus.ext_in_data),
    .i_pop   (w_rx_rd),
    .o_head  (w_rx_head),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  io_responder_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk     (clk),
    .i_init  (init),
    .i_push  (w_tx_wr),
    .i_wdata (bus.io_wdata),
    .i_pop   (bus.ext_out_ready),
    .o_head  (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  // Sticky set events: empty-RX read, full-TX write, INT while pending.
  assign w_set = {bus.intreq && r_irq_out,
                  w_tx_wr && w_tx_full,
                  w_rx_rd && w_rx_empty};

  assign w_status = DATA_W'({r_sticky, r_irq_out, w_tx_full, w_tx_empty,
                             w_rx_full, w_rx_empty});

  // IN data mux; an empty RX head is already zero.
  always_comb begin
    w_rd_val = '0;
    if (w_addr_ok) begin
      case (w_sel)
        A_DATA:   w_rd_val = w_rx_head;
        A_STATUS: w_rd_val = w_status;
        A_GPO:    w_rd_val = r_gpo;
        A_ID:     w_rd_val = L_ID;
        default:  w_rd_val = '0;
      endcase
    end
  end

  // IN result register; holds until the next IN.
  always_ff @(posedge clk) begin
    if (init)      r_rdata <= '0;
    else if (w_in) r_rdata <= w_rd_val;
  end

  // General-purpose output register.
  always_ff @(posedge clk) begin
    if (init)          r_gpo <= '0;
    else if (w_gpo_wr) r_gpo <= bus.io_wdata;
  end

  // Sticky bits: a STATUS read clears, but a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (init) r_sticky <= '0;
    else      r_sticky <= (r_sticky & ~{3{w_stat_rd}}) | w_set;
  end

  // Interrupt line: request wins over acknowledge; vector holds on ack.
  always_ff @(posedge clk) begin
    if (init) begin
      r_irq_out <= 1'b0;
      r_irq_vec <= '0;
    end else if (bus.intreq) begin
      r_irq_out <= 1'b1;
      r_irq_vec <= bus.io_addr;
    end else if (bus.irq_ack && r_irq_out) begin
      r_irq_out <= 1'b0;
    end
  end

  assign bus.io_rdata      = r_rdata;
  assign bus.gpo           = r_gpo;
  assign bus.irq_out       = r_irq_out;
  assign bus.irq_vec       = r_irq_vec;
  assign bus.ext_in_ready  = !w_rx_full;
  assign bus.ext_out_valid = !w_tx_empty;
  assign bus.ext_out_data  = w_tx_head;
endmodule
